// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial sequencer driving an external 1-bit full adder,
// LSB first, with a registered ripple carry and valid/ready on both sides.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid/in_ready        operand handshake; in_a, in_b, in_cin operands
//   fa_a/fa_b/fa_cin         to the full adder cell (zero outside RUN)
//   fa_sum/fa_cout           from the full adder cell (combinational)
//   out_valid/out_ready      result handshake; out_sum, out_cout result
//   busy                     high while an operation is in RUN or DONE
//   out_ovf                  signed overflow, only with SERIAL_ADD_OVF_EN
//
// Optional feature macro: SERIAL_ADD_OVF_EN
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_idx;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [WIDTH-1:0] w_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_run     = 1'b0;
        w_last    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
                if (r_idx == LAST) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shifts instead of variable bit-selects keep the index width free
    // of the operand width.
    assign w_a_sh = r_a >> r_idx;
    assign w_b_sh = r_b >> r_idx;
    assign w_bit  = {{(WIDTH-1){1'b0}}, fa_sum} << r_idx;

    assign fa_a   = w_run & w_a_sh[0];
    assign fa_b   = w_run & w_b_sh[0];
    assign fa_cin = w_run & r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sum   <= '0;
            r_carry <= in_cin;
            r_idx   <= '0;
        end else if (w_run) begin
            // sum was cleared on accept, so OR-ing in each bit is enough
            r_sum   <= r_sum | w_bit;
            r_carry <= fa_cout;
            r_idx   <= r_idx + ONE;
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_carry;

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // carry into the MSB is r_carry on the last step; XOR with carry-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_ovf <= 1'b0;
        else if (w_accept)         r_ovf <= 1'b0;
        else if (w_run && w_last)  r_ovf <= r_carry ^ fa_cout;
    end

    assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl (WIDTH=8)
// with a behavioural full adder cell and a result scoreboard queue.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         out_ovf;
`else
    logic         out_ovf;
    assign out_ovf = 1'b0;
`endif

    int n_cmp;
    int n_bad;

    // {ovf, cout, sum}
    logic [W+1:0] sb_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_cout  (fa_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .busy     (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`ifndef SERIAL_ADD_OVF_EN
        v = 1'b0;
`endif
        return {v, t};
    endfunction

    // Drives one request, pushes its expectation, returns what the DUT
    // produced and the accept-to-out_valid latency (-1 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output logic [W+1:0] obs,
                          output int lat);
        int k;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        sb_q.push_back(model(a, b, cin));
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = a ^ b;
        in_cin   = ~cin;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        obs = {out_ovf, out_cout, out_sum};
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({in_ready, out_valid, out_sum, out_cout, busy, fa_a, out_ovf}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_defaults: rdy=%b vld=%b sum=%h c=%b busy=%b want 1 0 00 0 0",
                     in_ready, out_valid, out_sum, out_cout, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_a     = 8'h0F;
        in_b     = 8'h01;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_sum, busy}
            !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_abort: rdy=%b vld=%b sum=%h busy=%b want 1 0 00 0",
                     in_ready, out_valid, out_sum, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_no_result: out_valid cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_basic();
        logic [W+1:0] obs;
        logic [W+1:0] exp;
        int           lat;
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vc[3];
        va = '{8'h5A, 8'hFF, 8'hFF};
        vb = '{8'h3C, 8'h01, 8'hFF};
        vc = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], obs, lat);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL basic_%0d: got ovf/c/sum=%h want %h", i, obs, exp);
            end
            n_cmp++;
            if (lat !== W) begin
                n_bad++;
                $display("FAIL latency_%0d: got %0d want %0d", i, lat, W);
            end
        end
        // hand-derived constants cross-check the model
        n_cmp++;
        if (exp[W:0] !== 9'h1FF) begin
            n_bad++;
            $display("FAIL ff_ff_1: got %h want 1ff", exp[W:0]);
        end
    endtask

    task automatic test_bit_seq();
        logic [W-1:0] a;
        logic [W+1:0] exp;
        int           k;
        a = 8'hA5;
        n_cmp++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            n_bad++;
            $display("FAIL fa_idle: got %b want 000", {fa_a, fa_b, fa_cin});
        end
        in_a     = a;
        in_b     = 8'h00;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        sb_q.push_back(model(a, 8'h00, 1'b0));
        tick();
        in_valid = 1'b0;
        in_a     = 8'h3C;
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if ({fa_a, fa_b, fa_cin} !== {a[i], 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL fa_bit_%0d: got %b want %b0",
                         i, {fa_a, fa_b, fa_cin}, {a[i], 1'b0});
            end
            if (i < W - 1) tick();
        end
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if ({out_valid, fa_a, fa_b, fa_cin} !== 4'b1000) begin
            n_bad++;
            $display("FAIL fa_done: vld/fa=%b want 1000",
                     {out_valid, fa_a, fa_b, fa_cin});
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if ({out_ovf, out_cout, out_sum} !== exp) begin
            n_bad++;
            $display("FAIL bitseq_result: got %h want %h",
                     {out_ovf, out_cout, out_sum}, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W+1:0] exp;
        int           k;
        int           bad;
        in_a     = 8'hC3;
        in_b     = 8'h5E;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        sb_q.push_back(model(8'hC3, 8'h5E, 1'b1));
        tick();
        in_a = 8'h11;
        in_b = 8'h22;
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({out_valid, in_ready, busy, out_ovf, out_cout, out_sum}
                !== {3'b101, exp}) bad++;
            tick();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: unstable cycles=%0d want 0 (last %h want %h)",
                     bad, {out_ovf, out_cout, out_sum}, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL bp_release: rdy/vld/busy=%b want 100",
                     {in_ready, out_valid, busy});
        end
        tick();
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_ignored_req: rdy/busy=%b want 10", {in_ready, busy});
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int gap;
        int k;
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (!(in_ready && in_valid) && k < 50) begin
            tick();
            k++;
        end
        t0 = 0;
        tick();
        gap = 1;
        while (!in_ready && gap < 50) begin
            tick();
            gap++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        n_cmp++;
        if (gap !== W + 2) begin
            n_bad++;
            $display("FAIL throughput: accept spacing=%0d want %0d", gap + t0, W + 2);
        end
        k = 0;
        while (busy && k < 50) begin
            out_ready = 1'b1;
            tick();
            k++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W+1:0] obs;
        logic [W+1:0] exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           lat;
        int           bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            run_op(a, b, c, obs, lat);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp || lat !== W) begin
                n_bad++;
                bad++;
                if (bad < 10)
                    $display("FAIL random: %h %h %b | got %h lat %0d want %h lat %0d",
                             a, b, c, obs, lat, exp, W);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_bit_seq();
        test_backpressure();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (sb_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: left=%0d want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
